sseg_scan_disp: RTL

Parametrised, time-multiplexed seven-segment display driver for DIGITS hex digits sharing one active-low segment bus, with per-digit enable, decimal point, blink and leading-zero blanking. Host logic loads a display image with a one-cycle strobe. The image is committed only at a frame boundary, so a digit is never shown half-updated. It sits between register/debug logic and the board's segment and digit-select pins, and replaces per-digit static decoders wherever pins are shared.

---
 rtl/sseg_scan_disp.sv | 80 ++++++++
 1 files changed

// File: rtl/sseg_scan_disp.sv
// sseg_scan_disp: multiplexed seven-segment driver with frame-aligned image commit, blink and leading-zero blanking
module sseg_scan_disp #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   en_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                lzb,
  output logic [7:0]          led,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_start,
  output logic                pending
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [16*7-1:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   blink;
    logic                lzb;
  } img_t;
  img_t in_img, shadow, active;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic phase, slot_end, wrap, guard, off, lz, dpe;
  logic [3:0] nib;
  logic [6:0] seg;
  logic [4*DIGITS-1:0] upper;
  assign in_img   = {data, dp, en_mask, blink_mask, lzb};
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign wrap     = slot_end && idx == IW'(DIGITS - 1);
  assign guard    = cnt < CW'(GUARD);
  always_comb begin
    nib   = active.data[4*idx +: 4];
    upper = active.data >> (4*idx);
    lz    = active.lzb && idx != '0 && upper == '0;
    off   = !active.en[idx] || (active.blink[idx] && phase);
    seg   = (off || lz) ? 7'h00 : GLYPHS[7*nib +: 7];
    dpe   = off ? 1'b0 : active.dp[idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      bcnt        <= '0;
      phase       <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      led         <= 8'hFF;
      dig_sel     <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= slot_end ? '0 : cnt + 1'b1;
      idx         <= wrap ? '0 : slot_end ? idx + 1'b1 : idx;
      bcnt        <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
      phase       <= bcnt == BW'(BLINK_DIV - 1) ? ~phase : phase;
      shadow      <= load ? in_img : shadow;
      active      <= wrap ? (load ? in_img : pending ? shadow : active) : active;
      pending     <= wrap ? 1'b0 : load ? 1'b1 : pending;
      led         <= guard ? 8'hFF : ~{dpe, seg};
      dig_sel     <= guard ? '1 : ~(DIGITS'(1) << idx);
      frame_start <= idx == '0 && cnt == '0;
    end
  end
endmodule
